// File: rtl/fft64_ctrl_pkg.sv
// fft64_ctrl_pkg: shared FSM state, frame sizes and data widths for the FFT frame controller.
package fft64_ctrl_pkg;
  localparam int N_PTS = 64;
  localparam int WD_MAX = 255;
  localparam int CW = $clog2(N_PTS);
  localparam int WDW = 8;
  localparam int DW_IN = 16;
  localparam int DW_OUT = 19;
  localparam int AW = 6;
  localparam int SW = 4;
  typedef enum logic [2:0] {S_IDLE, S_START, S_LOAD, S_WAIT, S_DRAIN} state_t;
endpackage

// File: rtl/fft64_shift_adapt.sv
// fft64_shift_adapt: sticky shift adjustment bumped after overflowing frames, added to cfg_shift with saturation.
module fft64_shift_adapt
  import fft64_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [SW-1:0] cfg_shift,
  input  logic          inc,
  output logic [SW-1:0] shift_sat
);
  logic [SW-1:0] shift_adj;
  logic [SW:0] sum;
  assign sum = {1'b0, cfg_shift} + {1'b0, shift_adj};
  assign shift_sat = sum[SW] ? '1 : sum[SW-1:0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) shift_adj <= '0;
    else if (inc && shift_adj != '1) shift_adj <= shift_adj + 1'b1;
  end
endmodule

// File: rtl/fft64_frame_ctrl.sv
// fft64_frame_ctrl: load/wait/drain sequencer between ready/valid streams and the 64-point FFT core.
// Define FFT_CTRL_AUTOSHIFT_EN to raise SHIFT automatically after frames that overflowed.
module fft64_frame_ctrl
  import fft64_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [SW-1:0]     cfg_shift,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW_IN-1:0]  in_re,
  input  logic [DW_IN-1:0]  in_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AW-1:0]     out_addr,
  output logic [DW_OUT-1:0] out_re,
  output logic [DW_OUT-1:0] out_im,
  output logic              out_last,
  output logic              core_start,
  output logic              core_ed,
  output logic [DW_IN-1:0]  core_dr,
  output logic [DW_IN-1:0]  core_di,
  output logic [SW-1:0]     core_shift,
  input  logic              core_rdy,
  input  logic              core_ovf1,
  input  logic              core_ovf2,
  input  logic [AW-1:0]     core_addr,
  input  logic [DW_OUT-1:0] core_dor,
  input  logic [DW_OUT-1:0] core_doi,
  output logic              busy,
  output logic              frame_ovf,
  output logic              err_timeout
);
  state_t state;
  logic [CW-1:0] cnt;
  logic [WDW-1:0] wd;
  logic [SW-1:0] shift_next;
  logic xfer, ovf_hit;
  assign busy = state != S_IDLE;
  assign in_ready = state == S_LOAD;
  assign core_start = state == S_START;
  assign out_valid = state == S_DRAIN || (state == S_WAIT && core_rdy);
  assign xfer = out_valid && out_ready;
  assign out_last = state == S_DRAIN && cnt == CW'(N_PTS - 1);
  // In WAIT the core is clocked freely until RDY, then it advances only with accepted results
  assign core_ed = state == S_LOAD  ? in_valid :
                   state == S_WAIT  ? (!core_rdy || out_ready) :
                   state == S_DRAIN ? out_ready : 1'b0;
  assign core_dr = in_ready ? in_re : '0;
  assign core_di = in_ready ? in_im : '0;
  assign out_addr = out_valid ? core_addr : '0;
  assign out_re = out_valid ? core_dor : '0;
  assign out_im = out_valid ? core_doi : '0;
  assign ovf_hit = core_ed && (core_ovf1 || core_ovf2);
`ifdef FFT_CTRL_AUTOSHIFT_EN
  fft64_shift_adapt u_shift_adapt (
    .clk       (clk),
    .rst       (rst),
    .cfg_shift (cfg_shift),
    .inc       (xfer && out_last && (frame_ovf || ovf_hit)),
    .shift_sat (shift_next)
  );
`else
  assign shift_next = cfg_shift;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      wd <= '0;
      core_shift <= '0;
      frame_ovf <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      frame_ovf <= state == S_START ? 1'b0 : frame_ovf || ovf_hit;
      case (state)
        S_IDLE: if (in_valid) begin
          state <= S_START;
          core_shift <= shift_next;
        end
        S_START: begin
          state <= S_LOAD;
          cnt <= '0;
        end
        S_LOAD: if (in_valid) begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(N_PTS - 1)) begin
            state <= S_WAIT;
            wd <= '0;
          end
        end
        S_WAIT: begin
          wd <= wd + 1'b1;
          if (core_rdy) begin
            state <= S_DRAIN;
            cnt <= CW'(xfer);
          end else if (wd == WDW'(WD_MAX - 1)) begin
            state <= S_IDLE;
            err_timeout <= 1'b1;
          end
        end
        S_DRAIN: if (out_ready) begin
          cnt <= cnt + 1'b1;
          if (out_last) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fft64_frame_ctrl.sv
// tb_fft64_frame_ctrl: table-driven frame scenarios plus watchdog and mid-frame reset sequences.
module tb_fft64_frame_ctrl;
`ifdef FFT_CTRL_AUTOSHIFT_EN
  localparam bit AS = 1'b1;
`else
  localparam bit AS = 1'b0;
`endif
  logic clk = 0, rst = 1;
  logic [3:0] cfg_shift = 0;
  logic in_valid = 0, in_ready;
  logic [15:0] in_re = 0, in_im = 0;
  logic out_valid, out_ready = 0, out_last;
  logic [5:0] out_addr;
  logic [18:0] out_re, out_im;
  logic core_start, core_ed;
  logic [15:0] core_dr, core_di;
  logic [3:0] core_shift;
  logic core_rdy = 0, core_ovf1 = 0, core_ovf2 = 0;
  logic [5:0] core_addr = 0;
  logic [18:0] core_dor = 0, core_doi = 0;
  logic busy, frame_ovf, err_timeout;
  int pass_cnt = 0, total_cnt = 0;

  fft64_frame_ctrl dut (
    .clk(clk), .rst(rst), .cfg_shift(cfg_shift),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_re(out_re), .out_im(out_im), .out_last(out_last),
    .core_start(core_start), .core_ed(core_ed), .core_dr(core_dr), .core_di(core_di),
    .core_shift(core_shift), .core_rdy(core_rdy), .core_ovf1(core_ovf1), .core_ovf2(core_ovf2),
    .core_addr(core_addr), .core_dor(core_dor), .core_doi(core_doi),
    .busy(busy), .frame_ovf(frame_ovf), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit gaps;
    int rdy_dly;
    int stall_at;
    int stall_len;
    logic [3:0] cfg;
    int ovf_at;
    logic [3:0] exp_shift;
    bit exp_ovf;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass_cnt++;
  endtask

  task automatic load_frame(input bit gaps, input int ovf_at, input int abort_at,
                            input logic [3:0] cfg, input logic [3:0] exp_shift, output int lc);
    int n = 0;
    bit v;
    lc = 0;
    cfg_shift = cfg;
    in_valid = 1;
    in_re = 16'd1;
    in_im = 16'hA5A5;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_in_ready", in_ready, 0);
    chk("idle_start", core_start, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("start_pulse", core_start, 1);
    chk("start_ed", core_ed, 0);
    chk("start_in_ready", in_ready, 0);
    chk("core_shift", core_shift, exp_shift);
    @(posedge clk); #1;
    while (n < 64 && lc < 500) begin
      if (n == abort_at) return;
      v = gaps ? (lc % 2 == 0) : 1'b1;
      in_valid = v;
      in_re = 16'(n * 5 + 1);
      in_im = 16'(n) ^ 16'hA5A5;
      core_ovf1 = v && n == ovf_at;
      @(negedge clk);
      if (lc == 0) chk("ovf_cleared", frame_ovf, 0);
      chk("load_ed", core_ed, v);
      chk("load_in_ready", in_ready, 1);
      chk("load_start", core_start, 0);
      chk("load_dr", core_dr, 16'(n * 5 + 1));
      chk("load_di", core_di, 16'(n) ^ 16'hA5A5);
      if (v) n++;
      lc++;
      @(posedge clk); #1;
    end
    in_valid = 0;
    core_ovf1 = 0;
  endtask

  task automatic drain(input int stall_at, input int stall_len, output int nres);
    int idx = 0, st = 0, cyc = 0;
    while (idx < 64 && cyc < 1000) begin
      core_rdy = cyc == 0;
      core_addr = 6'(idx);
      core_dor = 19'h40000 | 19'(idx);
      core_doi = 19'(idx * 7);
      out_ready = !(idx == stall_at && st < stall_len);
      @(negedge clk);
      chk("out_valid", out_valid, 1);
      chk("out_addr", out_addr, idx);
      chk("out_re", out_re, 32'h40000 | idx);
      chk("out_im", out_im, idx * 7);
      chk("out_last", out_last, idx == 63);
      chk("drain_ed", core_ed, out_ready);
      if (out_ready) idx++;
      else st++;
      cyc++;
      @(posedge clk); #1;
    end
    core_rdy = 0;
    out_ready = 0;
    nres = idx;
    @(negedge clk);
    chk("busy_after_last", busy, 0);
    chk("out_valid_idle", out_valid, 0);
  endtask

  task automatic run_frame(input vec_t v);
    int lc, nres;
    load_frame(v.gaps, v.ovf_at, -1, v.cfg, v.exp_shift, lc);
    chk("load_cycles", lc, v.gaps ? 127 : 64);
    repeat (v.rdy_dly) begin
      @(negedge clk);
      chk("wait_ed", core_ed, 1);
      chk("wait_in_ready", in_ready, 0);
      chk("wait_out_valid", out_valid, 0);
      chk("wait_busy", busy, 1);
      @(posedge clk); #1;
    end
    drain(v.stall_at, v.stall_len, nres);
    chk("n_results", nres, 64);
    chk("frame_ovf", frame_ovf, v.exp_ovf);
    @(posedge clk); #1;
  endtask

  vec_t vecs[6];

  initial begin
    int k, lc;
    vec_t hv;
    vecs[0] = '{0, 10, -1, 0, 4'd3, -1, 4'd3, 0};
    vecs[1] = '{1, 3, -1, 0, 4'd5, -1, 4'd5, 0};
    vecs[2] = '{0, 0, 10, 5, 4'd0, -1, 4'd0, 0};
    vecs[3] = '{0, 2, -1, 0, 4'd14, 20, 4'd14, 1};
    vecs[4] = '{0, 1, -1, 0, 4'd14, 5, AS ? 4'd15 : 4'd14, 1};
    vecs[5] = '{0, 4, -1, 0, 4'd14, -1, AS ? 4'd15 : 4'd14, 0};
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_shift", core_shift, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_ovf", frame_ovf, 0);
    chk("rst_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) run_frame(vecs[i]);
    load_frame(0, -1, -1, 4'd3, AS ? 4'd5 : 4'd3, lc);
    k = 0;
    while (!err_timeout && k < 400) begin
      @(negedge clk);
      if (k == 0) chk("wd_ed", core_ed, 1);
      @(posedge clk); #1;
      k++;
    end
    chk("wd_cycles", k, 255);
    chk("wd_idle", busy, 0);
    hv = '{0, 6, -1, 0, 4'd3, -1, AS ? 4'd5 : 4'd3, 0};
    run_frame(hv);
    chk("err_sticky", err_timeout, 1);
    load_frame(0, -1, 30, 4'd3, AS ? 4'd5 : 4'd3, lc);
    rst = 1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_ed", core_ed, 0);
    chk("mid_rst_dr", core_dr, 0);
    chk("mid_rst_shift", core_shift, 0);
    chk("mid_rst_err", err_timeout, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    in_valid = 0;
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    hv = '{0, 10, -1, 0, 4'd3, -1, 4'd3, 0};
    run_frame(hv);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
